// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Package : rsa_pkg
// Shared FSM state encoding and latency helper for the modexp engine.
// Rev     : 1.0
// ============================================================================
package rsa_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_MONT = 3'd2,
      S_CALC = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Cycles from the start-sampling cycle to the o_finished cycle.
   function automatic int modexp_latency(input int width, input int exp_width);
      return 1 + (width + 1) + exp_width * (width + 2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_modexp_core_if.sv
`default_nettype none
// ============================================================================
// Interface : rsa_modexp_core_if
// Operand / result / handshake bundle between the register file and the core.
// Rev       : 1.0
// ============================================================================
interface rsa_modexp_core_if #(
   parameter int WIDTH     = 256,
   parameter int EXP_WIDTH = 256
) ();
   logic                 i_start;
   logic [WIDTH-1:0]     i_a;
   logic [EXP_WIDTH-1:0] i_d;
   logic [WIDTH-1:0]     i_n;
   logic [WIDTH-1:0]     o_a_pow_d;
   logic                 o_finished;
   logic                 o_busy;

   modport master (
      output i_start, i_a, i_d, i_n,
      input  o_a_pow_d, o_finished, o_busy
   );

   modport slave (
      input  i_start, i_a, i_d, i_n,
      output o_a_pow_d, o_finished, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/mont_mul.sv
`default_nettype none
// ============================================================================
// Module : mont_mul
// Bit-serial Montgomery multiply: o_result = x*y*2^-WIDTH mod n, WIDTH+1 cycles.
// Rev    : 1.0
// ============================================================================
module mont_mul #(
   parameter int WIDTH = 256
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   input  logic [WIDTH-1:0] i_n,
   output logic [WIDTH-1:0] o_result,
   output logic             o_done
);
   localparam int c_CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_n;
   logic [WIDTH+1:0] r_acc;
   logic [c_CW-1:0]  r_cnt;
   logic             r_run;
   logic             r_done;
   logic [WIDTH-1:0] r_result;

   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_n;
   logic             w_ybit;
   logic [WIDTH+1:0] w_acc_in;
   logic [WIDTH+1:0] w_sum1;
   logic [WIDTH+1:0] w_sum2;
   logic [WIDTH+1:0] w_acc_next;
   logic             w_red_ge;
   logic [WIDTH-1:0] w_red;

   // The start cycle already performs iteration 0 straight from the inputs.
   always_comb begin
      w_x        = r_run ? r_x : i_x;
      w_n        = r_run ? r_n : i_n;
      w_ybit     = r_run ? r_y[0] : i_y[0];
      w_acc_in   = r_run ? r_acc : '0;
      w_sum1     = w_acc_in + (w_ybit ? {2'b00, w_x} : '0);
      w_sum2     = w_sum1 + (w_sum1[0] ? {2'b00, w_n} : '0);
      w_acc_next = w_sum2 >> 1;
      w_red_ge   = (r_acc[WIDTH+1:WIDTH] != 2'b00) || (r_acc[WIDTH-1:0] >= r_n);
      w_red      = w_red_ge ? (r_acc[WIDTH-1:0] - r_n) : r_acc[WIDTH-1:0];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_x      <= '0;
         r_y      <= '0;
         r_n      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else if (r_run) begin
         r_acc <= w_acc_next;
         r_y   <= r_y >> 1;
         r_cnt <= r_cnt + c_CW'(1);
         if (r_cnt == c_CW'(WIDTH - 1)) begin
            r_run  <= 1'b0;
            r_done <= 1'b1;
         end
      end else begin
         r_done <= 1'b0;
         // Final cycle: the done pulse is visible while the conditional subtract lands.
         if (r_done) begin
            r_result <= w_red;
         end
         if (i_start) begin
            r_x   <= i_x;
            r_y   <= i_y >> 1;
            r_n   <= i_n;
            r_acc <= w_acc_next;
            r_cnt <= c_CW'(1);
            r_run <= 1'b1;
         end
      end
   end

   assign o_result = r_result;
   assign o_done   = r_done;

endmodule
`default_nettype wire

// File: rtl/rsa_modexp_core.sv
`default_nettype none
// ============================================================================
// Module : rsa_modexp_core
// Right-to-left binary modular exponentiation a^d mod n over Montgomery multiply.
// Rev    : 1.0
// ============================================================================
module rsa_modexp_core
   import rsa_pkg::*;
#(
   parameter int WIDTH     = 256,
   parameter int EXP_WIDTH = 256
) (
   input  logic             i_clk,
   input  logic             i_rst,
   rsa_modexp_core_if.slave bus
);
   localparam int c_PREP_CW = $clog2(WIDTH + 1);
   localparam int c_EXP_CW  = $clog2(EXP_WIDTH + 1);

   state_t                 r_state;
   logic [WIDTH-1:0]       r_a;
   logic [EXP_WIDTH-1:0]   r_d;
   logic [WIDTH-1:0]       r_n;
   logic [WIDTH-1:0]       r_t;
   logic [WIDTH-1:0]       r_m;
   logic [WIDTH-1:0]       r_result;
   logic [c_PREP_CW-1:0]   r_prep_cnt;
   logic [c_EXP_CW-1:0]    r_exp_idx;
   logic                   r_busy;
   logic                   r_finished;
   logic                   r_mm_start;

   logic [WIDTH-1:0]       w_mp;
   logic [WIDTH-1:0]       w_tp;
   logic                   w_mp_done;
   logic                   w_tp_done;
   logic [WIDTH-1:0]       w_t_dbl;
   logic                   w_t_ge;
   logic [WIDTH-1:0]       w_t_prep;
   logic [WIDTH-1:0]       w_m_next;

   // Doubling step of a*2^WIDTH mod n; the shifted-out MSB counts toward >= n.
   always_comb begin
      w_t_dbl  = {r_t[WIDTH-2:0], 1'b0};
      w_t_ge   = r_t[WIDTH-1] || (w_t_dbl >= r_n);
      w_t_prep = w_t_ge ? (w_t_dbl - r_n) : w_t_dbl;
      w_m_next = r_d[0] ? w_mp : r_m;
   end

   mont_mul #(.WIDTH(WIDTH)) u_mm_m (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_start  (r_mm_start),
      .i_x      (r_m),
      .i_y      (r_t),
      .i_n      (r_n),
      .o_result (w_mp),
      .o_done   (w_mp_done)
   );

   mont_mul #(.WIDTH(WIDTH)) u_mm_t (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_start  (r_mm_start),
      .i_x      (r_t),
      .i_y      (r_t),
      .i_n      (r_n),
      .o_result (w_tp),
      .o_done   (w_tp_done)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_d        <= '0;
         r_n        <= '0;
         r_t        <= '0;
         r_m        <= '0;
         r_result   <= '0;
         r_prep_cnt <= '0;
         r_exp_idx  <= '0;
         r_busy     <= 1'b0;
         r_finished <= 1'b0;
         r_mm_start <= 1'b0;
      end else begin
         r_mm_start <= 1'b0;
         r_finished <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_a        <= bus.i_a;
                  r_d        <= bus.i_d;
                  r_n        <= bus.i_n;
                  r_prep_cnt <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_PREP;
               end
            end
            S_PREP: begin
               if (r_prep_cnt == '0) begin
                  r_t       <= r_a;
                  r_m       <= WIDTH'(1);
                  r_exp_idx <= '0;
               end else begin
                  r_t <= w_t_prep;
               end
               r_prep_cnt <= r_prep_cnt + c_PREP_CW'(1);
               if (r_prep_cnt == c_PREP_CW'(WIDTH)) begin
                  r_mm_start <= 1'b1;
                  r_state    <= S_MONT;
               end
            end
            S_MONT: begin
               if (w_mp_done && w_tp_done) begin
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               // Exponent is consumed LSB first by shifting r_d.
               r_m       <= w_m_next;
               r_t       <= w_tp;
               r_d       <= r_d >> 1;
               r_exp_idx <= r_exp_idx + c_EXP_CW'(1);
               if (r_exp_idx == c_EXP_CW'(EXP_WIDTH - 1)) begin
                  r_result   <= w_m_next;
                  r_finished <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_mm_start <= 1'b1;
                  r_state    <= S_MONT;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_a_pow_d  = r_result;
   assign bus.o_finished = r_finished;
   assign bus.o_busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp_core.sv
`default_nettype none
// ============================================================================
// Module : tb_rsa_modexp_core
// Directed self-checking bench for rsa_modexp_core at WIDTH=8, EXP_WIDTH=8.
// Rev    : 1.0
// ============================================================================
module tb_rsa_modexp_core;
   localparam int W   = 8;
   localparam int E   = 8;
   localparam int LAT = 90;
   localparam int RUN = 110;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rsa_modexp_core_if #(.WIDTH(W), .EXP_WIDTH(E)) bus ();

   rsa_modexp_core #(.WIDTH(W), .EXP_WIDTH(E)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // One operation: start at cycle 0, optional extra start pulses, RUN cycles observed.
   task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] n, input logic [7:0] exp_res,
                         input int p1, input int p2);
      int         fin_cycle = 0;
      int         pulses = 0;
      int         busy_bad = 0;
      logic [7:0] res_fin = 8'h00;
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_a = a;
      bus.i_d = d;
      bus.i_n = n;
      @(posedge clk);
      #1;
      bus.i_a = 8'hff;
      bus.i_d = 8'h5a;
      bus.i_n = 8'h0f;
      for (int c = 1; c <= RUN; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         bus.i_start = (c == p1) || (c == p2);
         if (bus.o_busy !== ((c <= LAT) ? 1'b1 : 1'b0)) busy_bad++;
         if (bus.o_finished === 1'b1) begin
            pulses++;
            if (fin_cycle == 0) begin
               fin_cycle = c;
               res_fin = bus.o_a_pow_d;
            end
         end
      end
      bus.i_start = 1'b0;
      checks++;
      if (fin_cycle != LAT) begin
         errors++;
         $display("FAIL %s latency: got cycle %0d, expected %0d", name, fin_cycle, LAT);
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL %s finished_pulses: got %0d, expected 1", name, pulses);
      end
      checks++;
      if (busy_bad != 0) begin
         errors++;
         $display("FAIL %s busy_window: got %0d bad cycles, expected 0", name, busy_bad);
      end
      checks++;
      if (res_fin !== exp_res) begin
         errors++;
         $display("FAIL %s result_at_finish: got %0d, expected %0d", name, res_fin, exp_res);
      end
      checks++;
      if (bus.o_a_pow_d !== exp_res) begin
         errors++;
         $display("FAIL %s result_held: got %0d, expected %0d", name, bus.o_a_pow_d, exp_res);
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b, expected 0", bus.o_busy);
      end
      checks++;
      if (bus.o_finished !== 1'b0) begin
         errors++;
         $display("FAIL reset_finished: got %b, expected 0", bus.o_finished);
      end
      checks++;
      if (bus.o_a_pow_d !== 8'd0) begin
         errors++;
         $display("FAIL reset_result: got %0d, expected 0", bus.o_a_pow_d);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      run_op("basic", 8'd4, 8'd13, 8'd143, 8'd108, 0, 0);
   endtask

   task automatic test_zero_exponent();
      run_op("zero_exp", 8'd5, 8'd0, 8'd143, 8'd1, 0, 0);
   endtask

   task automatic test_zero_base();
      run_op("zero_base", 8'd0, 8'd5, 8'd143, 8'd0, 0, 0);
   endtask

   task automatic test_ignored_start();
      run_op("ignored_start", 8'd4, 8'd13, 8'd143, 8'd108, 10, 90);
   endtask

   task automatic test_reset_mid();
      run_op("pre_reset", 8'd4, 8'd13, 8'd143, 8'd108, 0, 0);
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_a = 8'd4;
      bus.i_d = 8'd13;
      bus.i_n = 8'd143;
      @(posedge clk);
      #1 bus.i_start = 1'b0;
      for (int c = 2; c <= 40; c++) @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (bus.o_busy !== 1'b0 || bus.o_finished !== 1'b0 || bus.o_a_pow_d !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs[%0d]: got busy=%b fin=%b res=%0d, expected all 0",
                     k, bus.o_busy, bus.o_finished, bus.o_a_pow_d);
         end
         @(posedge clk);
      end
      @(negedge clk);
      rst = 1'b0;
      run_op("restart", 8'd2, 8'd7, 8'd11, 8'd7, 0, 0);
   endtask

   task automatic test_boundaries();
      run_op("a_is_n_minus_1", 8'd142, 8'd1, 8'd143, 8'd142, 0, 0);
      run_op("n_is_3", 8'd2, 8'd255, 8'd3, 8'd2, 0, 0);
      run_op("full_exponent", 8'd7, 8'd255, 8'd13, 8'd5, 0, 0);
   endtask

   initial begin
      bus.i_start = 1'b0;
      bus.i_a = '0;
      bus.i_d = '0;
      bus.i_n = '0;
      test_reset();
      test_basic();
      test_zero_exponent();
      test_zero_base();
      test_ignored_start();
      test_reset_mid();
      test_boundaries();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
